serial_window_detector: RTL and testbench
=========================================

// Module: serial_window_detector
// PURPOSE
//  Parametrised sliding-window detector for a 1-bit serial stream: keeps the last WIN_LEN bits
//  and flags a hit when the window meets a runtime-selected rule (exactly K ones, at least K ones,
//  or masked pattern match). Counts hits in a saturating counter.
//  Sits after the serial sampler in the receive path, feeding the status/interrupt logic.
//  Default config (WIN_LEN=3, mode EXACT, k_thresh=2) gives the "exactly 2 of last 3 are 1" detector.
// PARAMETERS
//  WIN_LEN  3   window length in bits; legal range 2..32
//  HIT_W    16  hit_count width in bits; legal range >=1
//  CNT_W    $clog2(WIN_LEN+1)  derived (localparam): width of ones_count and k_thresh
// PORTS
//  clk            in   1        clock; all logic on posedge
//  rstb           in   1        synchronous active-low reset
//  enable         in   1        1 = sample serial_in each cycle; 0 = flush window, hold hit_count
//  serial_in      in   1        serial data bit, sampled on each posedge while enable=1
//  mode           in   2        00 EXACT, 01 ATLEAST, 10 MATCH, 11 reserved (never hits)
//  k_thresh       in   CNT_W    ones threshold K for EXACT/ATLEAST
//  match_pattern  in   WIN_LEN  MATCH pattern; bit0 = newest bit
//  match_mask     in   WIN_LEN  MATCH care mask; 1 = compare this bit
//  count_clr      in   1        synchronous clear of hit_count
//  detect         out  1        registered hit flag for the current window
//  window_full    out  1        1 once WIN_LEN bits are held since the last enable rise or reset
//  ones_count     out  CNT_W    popcount of the valid window bits
//  hit_count      out  HIT_W    saturating count of detect=1 cycles
// BEHAVIOUR
//  - Reset (rstb=0 at posedge): state=IDLE; window, fill count, ones_count, detect, window_full,
//    hit_count all 0. Takes priority over every other input.
//  - FSM: IDLE --enable--> FILL --(WIN_LEN-th bit sampled)--> RUN. enable=0 in any state -> IDLE.
//    In IDLE: window, fill count, ones_count, detect and window_full clear to 0. hit_count holds.
//  - Shift: window_next = {window[WIN_LEN-2:0], serial_in}. window[0] = newest bit,
//    window[WIN_LEN-1] = oldest.
//  - Fill: in FILL, the count of bits held increments per sample. window_full is 1 in RUN only.
//  - ones_count updates incrementally: ones_next = ones + serial_in - (RUN ? window[WIN_LEN-1] : 0).
//    It never exceeds WIN_LEN.
//  - Hit rules are evaluated on the next-window values:
//    EXACT: ones_next == k_thresh.  ATLEAST: ones_next >= k_thresh.
//    MATCH: ((window_next ^ match_pattern) & match_mask) == 0.  mode 11: no hit.
//  - detect is registered and updates on the same edge that samples the bit completing the window.
//    No extra pipeline stage.
//  - detect=1 only when the edge leaves the FSM in RUN. The WIN_LEN-th sample counts, so the first
//    possible hit is on the WIN_LEN-th enabled edge.
//  - k_thresh > WIN_LEN: EXACT and ATLEAST never hit. k_thresh = 0: ATLEAST hits every RUN cycle.
//    MATCH with match_mask = 0 hits every RUN cycle.
//  - Config inputs (mode, k_thresh, match_*) are not registered. A change applies from the next edge.
//    No window flush on a config change.
//  - hit_count: increments by 1 on each edge where detect becomes or stays 1. It saturates at
//    2^HIT_W-1 and does not wrap.
//    count_clr=1 forces 0 and wins over a simultaneous increment. rstb also clears it; enable=0 does not.
//  - Reset or enable drop mid-window discards partial data. A re-enable must refill WIN_LEN bits
//    before any hit.
// STRUCTURE
//  - Package pattern_det_pkg holds det_mode_e (EXACT/ATLEAST/MATCH/RSVD) and det_state_e
//    (IDLE/FILL/RUN).
//  - Sub-module sat_counter #(W) (clk, rstb, clr, inc, count) is instantiated for hit_count and
//    reused elsewhere.
//  - Top level holds the FSM, shift register, incremental popcount, rule compare, and detect flop.
// TESTING
//  1. Defaults (N=3, EXACT, K=2), stream 1,1,0,1,1,1 -> detect 0,0,1,1,1,0; window_full 0,0,1,1,1,1;
//     hit_count ends at 3.
//  2. N=4, MATCH, pattern=4'b1011, mask=4'hF, stream 1,0,1,1,0,1,1 -> detect=1 after bits 4 and 7 only.
//     With mask=4'b0011, any stream ending ..1,1 hits once window_full=1.
//  3. ATLEAST K=2 in RUN with a continuous hit; drop enable for 1 cycle -> next edge detect=0,
//     ones_count=0, window_full=0, hit_count held; re-enable -> first hit again on 3rd enabled edge.
//  4. HIT_W=2, 5 consecutive hit cycles -> hit_count 1,2,3,3,3; count_clr=1 with detect=1 on the
//     same edge -> hit_count=0.
//  5. rstb=0 for 1 cycle mid-RUN with hit_count=7 -> all outputs 0 next edge; refill required before
//     a hit.
//  6. Edge configs in RUN: mode=11 -> detect stays 0; EXACT K=3 on N=3 all-ones stream -> hit;
//     ATLEAST K=0 -> detect=1 every RUN cycle.
//     Randomised stream vs reference model: detect/ones_count match every cycle.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// Shared types for the serial window detector: rule selection and FSM state encodings.
package pattern_det_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    EXACT   = 2'b00,
    ATLEAST = 2'b01,
    MATCH   = 2'b10,
    RSVD    = 2'b11
  } det_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serial_window_detector.sv
// Sliding-window detector on a 1-bit stream: keeps the last WIN_LEN bits, flags windows that
// satisfy the selected rule and counts the flagged cycles.
module serial_window_detector
  import pattern_det_pkg::*;
#(
  parameter  int WIN_LEN = 3,
  parameter  int HIT_W   = 16,
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic               serial_in,
  input  logic [MODE_W-1:0]  mode,
  input  logic [CNT_W-1:0]   k_thresh,
  input  logic [WIN_LEN-1:0] match_pattern,
  input  logic [WIN_LEN-1:0] match_mask,
  input  logic               count_clr,
  output logic               detect,
  output logic               window_full,
  output logic [CNT_W-1:0]   ones_count,
  output logic [HIT_W-1:0]   hit_count,
  output det_state_e         state_dbg
);

  localparam logic [CNT_W-1:0] WIN_LEN_C = CNT_W'(WIN_LEN);

  det_state_e         state_q, state_d;
  logic [WIN_LEN-1:0] window_q, window_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic [CNT_W-1:0]   fill_inc;
  logic [CNT_W:0]     ones_sum;
  logic               drop_bit;
  logic               rule_hit;
  logic               detect_d;

  // Next window, fill level and popcount; enable low flushes everything back to IDLE.
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    ones_d   = ones_q;
    fill_inc = fill_q + CNT_W'(1);
    drop_bit = (state_q == RUN) ? window_q[WIN_LEN-1] : 1'b0;
    ones_sum = {1'b0, ones_q} + {{CNT_W{1'b0}}, serial_in} - {{CNT_W{1'b0}}, drop_bit};

    if (!enable) begin
      state_d  = IDLE;
      window_d = '0;
      fill_d   = '0;
      ones_d   = '0;
    end else begin
      window_d = {window_q[WIN_LEN-2:0], serial_in};
      ones_d   = ones_sum[CNT_W-1:0];
      case (state_q)
        IDLE, FILL: begin
          fill_d  = fill_inc;
          state_d = (fill_inc == WIN_LEN_C) ? RUN : FILL;
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Rules look at the window as it will be after this edge, so detect needs no extra stage.
  always_comb begin
    rule_hit = 1'b0;
    case (det_mode_e'(mode))
      EXACT:   rule_hit = (ones_d == k_thresh);
      ATLEAST: rule_hit = (ones_d >= k_thresh);
      MATCH:   rule_hit = (((window_d ^ match_pattern) & match_mask) == '0);
      default: rule_hit = 1'b0;
    endcase
    detect_d = enable && (state_d == RUN) && rule_hit;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= IDLE;
      window_q <= '0;
      fill_q   <= '0;
      ones_q   <= '0;
      detect   <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      ones_q   <= ones_d;
      detect   <= detect_d;
    end
  end

  assign window_full = (state_q == RUN);
  assign ones_count  = ones_q;
  assign state_dbg   = state_q;

  sat_counter #(
    .W(HIT_W)
  ) u_hit_counter (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (count_clr),
    .inc   (detect_d),
    .count (hit_count)
  );

endmodule

// File: tb/tb_serial_window_detector.sv
// Bench for serial_window_detector: three configurations share one stream and are each checked
// every cycle against a bit-history model, plus directed expectations for the listed scenarios.
module tb_serial_window_detector;
  import pattern_det_pkg::*;

  logic clk = 1'b0;
  logic rstb, enable, serial_in, count_clr;
  logic [1:0] mode;
  logic [1:0] k3;
  logic [2:0] k4;
  logic [2:0] p3, m3;
  logic [3:0] p4, m4;

  logic        a_det, a_full;
  logic [1:0]  a_ones;
  logic [15:0] a_hit;
  det_state_e  a_st;
  logic        b_det, b_full;
  logic [2:0]  b_ones;
  logic [15:0] b_hit;
  det_state_e  b_st;
  logic        c_det, c_full;
  logic [1:0]  c_ones;
  logic [1:0]  c_hit;
  det_state_e  c_st;

  int n_checks = 0;
  int n_fail   = 0;
  string cur_tag = "init";

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  serial_window_detector #(.WIN_LEN(3), .HIT_W(16)) u_a (
    .clk(clk), .rstb(rstb), .enable(enable), .serial_in(serial_in), .mode(mode),
    .k_thresh(k3), .match_pattern(p3), .match_mask(m3), .count_clr(count_clr),
    .detect(a_det), .window_full(a_full), .ones_count(a_ones), .hit_count(a_hit),
    .state_dbg(a_st)
  );

  serial_window_detector #(.WIN_LEN(4), .HIT_W(16)) u_b (
    .clk(clk), .rstb(rstb), .enable(enable), .serial_in(serial_in), .mode(mode),
    .k_thresh(k4), .match_pattern(p4), .match_mask(m4), .count_clr(count_clr),
    .detect(b_det), .window_full(b_full), .ones_count(b_ones), .hit_count(b_hit),
    .state_dbg(b_st)
  );

  serial_window_detector #(.WIN_LEN(3), .HIT_W(2)) u_c (
    .clk(clk), .rstb(rstb), .enable(enable), .serial_in(serial_in), .mode(mode),
    .k_thresh(k3), .match_pattern(p3), .match_mask(m3), .count_clr(count_clr),
    .detect(c_det), .window_full(c_full), .ones_count(c_ones), .hit_count(c_hit),
    .state_dbg(c_st)
  );

  // reference model: raw bit history since enable, rules applied to the last N bits
  logic [31:0] m_hist [3];
  int          m_fill [3];
  int          m_ones [3];
  int          m_hit  [3];
  logic        m_det  [3];
  logic        m_full [3];
  int          n_of   [3] = '{3, 4, 3};
  int          max_of [3] = '{65535, 65535, 3};

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int          kk;
      logic [31:0] pat, msk, vmask, nmask, win;
      logic        hit;
      kk  = (d == 1) ? int'(k4) : int'(k3);
      pat = (d == 1) ? 32'(p4) : 32'(p3);
      msk = (d == 1) ? 32'(m4) : 32'(m3);
      if (!rstb) begin
        m_hist[d] = '0; m_fill[d] = 0; m_ones[d] = 0;
        m_det[d] = 1'b0; m_full[d] = 1'b0; m_hit[d] = 0;
      end else if (!enable) begin
        m_hist[d] = '0; m_fill[d] = 0; m_ones[d] = 0;
        m_det[d] = 1'b0; m_full[d] = 1'b0;
        if (count_clr) m_hit[d] = 0;
      end else begin
        m_hist[d] = {m_hist[d][30:0], serial_in};
        if (m_fill[d] < n_of[d]) m_fill[d] = m_fill[d] + 1;
        m_full[d] = (m_fill[d] == n_of[d]);
        vmask = (32'h1 << m_fill[d]) - 32'h1;
        nmask = (32'h1 << n_of[d]) - 32'h1;
        win   = m_hist[d] & nmask;
        m_ones[d] = $countones(m_hist[d] & vmask);
        case (mode)
          2'd0:    hit = (m_ones[d] == kk);
          2'd1:    hit = (m_ones[d] >= kk);
          2'd2:    hit = (((win ^ pat) & msk) == 32'h0);
          default: hit = 1'b0;
        endcase
        m_det[d] = m_full[d] && hit;
        if (count_clr) m_hit[d] = 0;
        else if (m_det[d] && (m_hit[d] < max_of[d])) m_hit[d] = m_hit[d] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: every DUT output against the model after each edge
  task automatic check_all();
    chk({cur_tag, " a.detect"}, 32'(a_det),  32'(m_det[0]));
    chk({cur_tag, " a.full"},   32'(a_full), 32'(m_full[0]));
    chk({cur_tag, " a.ones"},   32'(a_ones), 32'(m_ones[0]));
    chk({cur_tag, " a.hit"},    32'(a_hit),  32'(m_hit[0]));
    chk({cur_tag, " b.detect"}, 32'(b_det),  32'(m_det[1]));
    chk({cur_tag, " b.full"},   32'(b_full), 32'(m_full[1]));
    chk({cur_tag, " b.ones"},   32'(b_ones), 32'(m_ones[1]));
    chk({cur_tag, " b.hit"},    32'(b_hit),  32'(m_hit[1]));
    chk({cur_tag, " c.detect"}, 32'(c_det),  32'(m_det[2]));
    chk({cur_tag, " c.full"},   32'(c_full), 32'(m_full[2]));
    chk({cur_tag, " c.ones"},   32'(c_ones), 32'(m_ones[2]));
    chk({cur_tag, " c.hit"},    32'(c_hit),  32'(m_hit[2]));
  endtask

  // driver tasks
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic feed(input logic b);
    serial_in = b;
    step();
  endtask

  initial begin
    logic [5:0] s1, e1, f1;
    logic [6:0] s2, e2;
    logic [2:0] s3, e3;
    logic [4:0] e4;
    int h_saved;

    s1 = 6'b111011; e1 = 6'b011100; f1 = 6'b111100;
    s2 = 7'b1101101; e2 = 7'b1001000;
    s3 = 3'b110; e3 = 3'b100;
    e4 = {2'd3, 3'b0};

    rstb = 1'b0; enable = 1'b0; serial_in = 1'b0; count_clr = 1'b0;
    mode = 2'd0; k3 = 2'd2; k4 = 3'd2;
    p3 = 3'b0; m3 = 3'b0; p4 = 4'b0; m4 = 4'b0;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = '0; m_fill[i] = 0; m_ones[i] = 0; m_hit[i] = 0;
      m_det[i] = 1'b0; m_full[i] = 1'b0;
    end

    cur_tag = "reset";
    step();
    step();
    chk("reset a.detect", 32'(a_det), 32'd0);
    chk("reset a.full",   32'(a_full), 32'd0);
    chk("reset a.ones",   32'(a_ones), 32'd0);
    chk("reset a.hit",    32'(a_hit), 32'd0);
    chk("reset a.state",  32'(a_st), 32'(IDLE));

    // exactly 2 of last 3
    cur_tag = "t1";
    rstb = 1'b1; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feed(s1[i]);
      chk($sformatf("t1 a.detect[%0d]", i), 32'(a_det), 32'(e1[i]));
      chk($sformatf("t1 a.full[%0d]", i), 32'(a_full), 32'(f1[i]));
    end
    chk("t1 a.hit end", 32'(a_hit), 32'd3);
    chk("t1 a.state", 32'(a_st), 32'(RUN));

    // masked pattern match on the 4-bit instance
    cur_tag = "t2";
    enable = 1'b0;
    step();
    mode = 2'd2; p4 = 4'b1011; m4 = 4'hF; p3 = 3'b011; m3 = 3'b111;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      feed(s2[i]);
      chk($sformatf("t2 b.detect[%0d]", i), 32'(b_det), 32'(e2[i]));
    end
    m4 = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      feed(s3[i]);
      chk($sformatf("t2 mask b.detect[%0d]", i), 32'(b_det), 32'(e3[i]));
    end

    // enable drop in the middle of a hit run
    cur_tag = "t3";
    mode = 2'd1; k3 = 2'd2; k4 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      feed(1'b1);
      chk("t3 a.detect run", 32'(a_det), 32'd1);
    end
    h_saved = m_hit[0];
    enable = 1'b0;
    step();
    chk("t3 drop a.detect", 32'(a_det), 32'd0);
    chk("t3 drop a.ones", 32'(a_ones), 32'd0);
    chk("t3 drop a.full", 32'(a_full), 32'd0);
    chk("t3 drop a.hit held", 32'(a_hit), 32'(h_saved));
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed(1'b1);
      chk($sformatf("t3 refill a.detect[%0d]", i), 32'(a_det), (i == 2) ? 32'd1 : 32'd0);
    end

    // saturation of the 2-bit counter and clear precedence
    cur_tag = "t4";
    enable = 1'b0; count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    chk("t4 c.hit cleared", 32'(c_hit), 32'd0);
    mode = 2'd1; k3 = 2'd0; k4 = 3'd0; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      feed(1'($urandom_range(0, 1)));
      if (i >= 2) begin
        chk($sformatf("t4 c.detect[%0d]", i), 32'(c_det), 32'd1);
        chk($sformatf("t4 c.hit[%0d]", i), 32'(c_hit), (i == 2) ? 32'd1 : (i == 3) ? 32'd2 : 32'(e4[4:3]));
      end
    end
    count_clr = 1'b1;
    feed(1'($urandom_range(0, 1)));
    count_clr = 1'b0;
    chk("t4 clr c.detect", 32'(c_det), 32'd1);
    chk("t4 clr c.hit", 32'(c_hit), 32'd0);
    chk("t4 clr a.hit", 32'(a_hit), 32'd0);

    // synchronous reset mid-run
    cur_tag = "t5";
    for (int i = 0; i < 7; i++) feed(1'($urandom_range(0, 1)));
    chk("t5 a.hit before reset", 32'(a_hit), 32'd7);
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    chk("t5 rst a.detect", 32'(a_det), 32'd0);
    chk("t5 rst a.full", 32'(a_full), 32'd0);
    chk("t5 rst a.ones", 32'(a_ones), 32'd0);
    chk("t5 rst a.hit", 32'(a_hit), 32'd0);
    chk("t5 rst b.hit", 32'(b_hit), 32'd0);
    for (int i = 0; i < 3; i++) begin
      feed(1'b1);
      chk($sformatf("t5 refill a.detect[%0d]", i), 32'(a_det), (i == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t5 refill a.full[%0d]", i), 32'(a_full), (i == 2) ? 32'd1 : 32'd0);
    end

    // edge configurations while running
    cur_tag = "t6";
    mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      feed(1'($urandom_range(0, 1)));
      chk("t6 rsvd a.detect", 32'(a_det), 32'd0);
      chk("t6 rsvd b.detect", 32'(b_det), 32'd0);
    end
    mode = 2'd0; k3 = 2'd3; k4 = 3'd4;
    for (int i = 0; i < 4; i++) feed(1'b1);
    chk("t6 exact full a.detect", 32'(a_det), 32'd1);
    chk("t6 exact full b.detect", 32'(b_det), 32'd1);
    k4 = 3'd7;
    feed(1'b1);
    chk("t6 k over len b.detect", 32'(b_det), 32'd0);
    mode = 2'd1; k3 = 2'd0; k4 = 3'd0;
    for (int i = 0; i < 4; i++) begin
      feed(1'($urandom_range(0, 1)));
      chk("t6 atleast0 a.detect", 32'(a_det), 32'd1);
    end

    // randomized stream against the model
    cur_tag = "rand";
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mode = 2'($urandom_range(0, 3));
        k3   = 2'($urandom_range(0, 3));
        k4   = 3'($urandom_range(0, 7));
        p3   = 3'($urandom_range(0, 7));
        m3   = 3'($urandom_range(0, 7));
        p4   = 4'($urandom_range(0, 15));
        m4   = 4'($urandom_range(0, 15));
      end
      enable    = ($urandom_range(0, 15) != 0);
      count_clr = ($urandom_range(0, 31) == 0);
      rstb      = ($urandom_range(0, 63) != 0);
      feed(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
